// File: rtl/alu_issue_if.sv
// Handshake bundle between an instruction source/result sink and the ALU issue unit.
interface alu_issue_if #(
  parameter int W  = 4,
  parameter int RW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [RW-1:0] in_dst;
  logic [RW-1:0] in_src1;
  logic [RW-1:0] in_src2;
  logic          in_imm_en;
  logic [W-1:0]  in_imm;

  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [RW-1:0] out_dst;
  logic          out_err;

  // Instruction source and result sink side.
  modport master (
    output in_valid, in_op, in_dst, in_src1, in_src2, in_imm_en, in_imm, out_ready,
    input  in_ready, out_valid, out_data, out_dst, out_err
  );

  // Issue unit side.
  modport slave (
    input  in_valid, in_op, in_dst, in_src1, in_src2, in_imm_en, in_imm, out_ready,
    output in_ready, out_valid, out_data, out_dst, out_err
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Serial issue stage feeding a combinational ALU: one instruction at a time,
// operands from a small register file (r0 hardwired to zero) or an immediate,
// result written back and presented downstream over valid/ready.
module alu_issue_unit #(
  parameter int W    = 4,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_issue_if.slave    bus,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_code,
  input  logic [W-1:0]  alu_ans,
  output logic [7:0]    retired
);
  localparam int RW = $clog2(NREG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [RW-1:0] dst_q, dst_d;
  logic [RW-1:0] src1_q, src1_d;
  logic [RW-1:0] src2_q, src2_d;
  logic          imm_en_q, imm_en_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [RW-1:0] out_dst_q, out_dst_d;
  logic          out_err_q, out_err_d;
  logic [7:0]    retired_q, retired_d;
  logic [W-1:0]  regs_q [NREG];
  logic [W-1:0]  regs_d [NREG];

  logic          in_ready_c;
  logic          out_valid_c;
  logic          op_legal;

  assign op_legal      = (bus.in_op >= 4'd1) && (bus.in_op <= 4'd7);

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_dst   = out_dst_q;
  assign bus.out_err   = out_err_q;
  assign retired       = retired_q;

  // Next-state, handshake outputs, ALU drive and write-back for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    imm_en_d    = imm_en_q;
    imm_d       = imm_q;
    out_data_d  = out_data_q;
    out_dst_d   = out_dst_q;
    out_err_d   = out_err_q;
    retired_d   = retired_q;
    regs_d      = regs_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_code    = 4'd0;

    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          op_d     = bus.in_op;
          dst_d    = bus.in_dst;
          src1_d   = bus.in_src1;
          src2_d   = bus.in_src2;
          imm_en_d = bus.in_imm_en;
          imm_d    = bus.in_imm;
          if (op_legal) begin
            state_d = EXEC;
          end else begin
            // Illegal opcodes skip the ALU entirely and report an error result.
            state_d    = RESP;
            out_err_d  = 1'b1;
            out_data_d = '0;
            out_dst_d  = bus.in_dst;
          end
        end
      end
      EXEC: begin
        alu_a      = (src1_q == '0) ? '0 : regs_q[src1_q];
        alu_b      = imm_en_q ? imm_q : ((src2_q == '0) ? '0 : regs_q[src2_q]);
        alu_code   = op_q;
        out_data_d = alu_ans;
        out_dst_d  = dst_q;
        out_err_d  = 1'b0;
        if (dst_q != '0) begin
          regs_d[dst_q] = alu_ans;
        end
        retired_d = retired_q + 8'd1;
        state_d   = RESP;
      end
      RESP: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    regs_d[0] = '0;

    // While reset is held, nothing is accepted and the ALU sees zeros.
    if (rst) begin
      in_ready_c = 1'b0;
      alu_a      = '0;
      alu_b      = '0;
      alu_code   = 4'd0;
    end
  end

  // State, latched instruction, result and register file; reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= 4'd0;
      dst_q      <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      out_data_q <= '0;
      out_dst_q  <= '0;
      out_err_q  <= 1'b0;
      retired_q  <= 8'd0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm_en_q   <= imm_en_d;
      imm_q      <= imm_d;
      out_data_q <= out_data_d;
      out_dst_q  <= out_dst_d;
      out_err_q  <= out_err_d;
      retired_q  <= retired_d;
      regs_q     <= regs_d;
    end
  end
endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: a behavioural ALU drives alu_ans, a
// reference model predicts each response at issue time, and a monitor pops and
// compares whenever a response is consumed downstream.
module tb_alu_issue_unit;
  localparam int W    = 4;
  localparam int NREG = 4;
  localparam int RW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [3:0]    alu_code;
  logic [W-1:0]  alu_ans;
  logic [7:0]    retired;

  alu_issue_if #(.W(W), .RW(RW)) bus ();

  alu_issue_unit #(.W(W), .NREG(NREG)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_code (alu_code),
    .alu_ans  (alu_ans),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [RW-1:0] dst;
    logic          err;
    logic [7:0]    ret;
  } resp_t;

  resp_t        sb[$];
  int           errors = 0;
  int           checks = 0;
  int           last_wait = 0;
  int           model_retired = 0;
  logic [W-1:0] model_regs [NREG];
  bit           hold_low = 1'b0;
  bit           rand_ready = 1'b0;

  // Behavioural ALU: plain arithmetic modulo 2^W.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
    int ai = int'(a);
    int bi = int'(b);
    int r;
    case (op)
      4'd1:    r = ai + bi;
      4'd2:    r = ai - bi;
      4'd3:    r = (bi >= W) ? 0 : (ai * (1 << bi));
      4'd4:    r = (bi >= W) ? 0 : (ai / (1 << bi));
      4'd5:    r = ai & bi;
      4'd6:    r = ai | bi;
      4'd7:    r = (2 ** W - 1) - ai;
      default: r = 0;
    endcase
    return W'(r & (2 ** W - 1));
  endfunction

  always_comb alu_ans = ref_alu(alu_a, alu_b, alu_code);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Downstream sink: drives out_ready and compares every consumed response with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      bus.out_ready = 1'b0;
    end else begin
      if (hold_low)        bus.out_ready = 1'b0;
      else if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      else                 bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out_valid: got out_valid=1 required no pending response at %0t", $time);
        end else if (bus.out_ready) begin
          resp_t e;
          e = sb.pop_front();
          checkOutput("out_data", 32'(bus.out_data), 32'(e.data));
          checkOutput("out_dst", 32'(bus.out_dst), 32'(e.dst));
          checkOutput("out_err", 32'(bus.out_err), 32'(e.err));
          checkOutput("retired", 32'(retired), 32'(e.ret));
          checkOutput("in_ready_in_resp", 32'(bus.in_ready), 32'd0);
        end
      end
    end
  end

  // Issue one instruction, update the reference model and queue its expected response.
  task automatic applyStimulus(input logic [3:0] op, input logic [RW-1:0] dst, input logic [RW-1:0] src1,
                               input logic [RW-1:0] src2, input logic imm_en, input logic [W-1:0] imm);
    int           waited = 0;
    logic [W-1:0] a, b, ans;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    last_wait = waited;
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 after %0d cycles required 1", waited);
      return;
    end
    bus.in_op     = op;
    bus.in_dst    = dst;
    bus.in_src1   = src1;
    bus.in_src2   = src2;
    bus.in_imm_en = imm_en;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'($urandom);
    bus.in_imm    = W'($urandom);
    a = model_regs[src1];
    b = imm_en ? imm : model_regs[src2];
    if (op >= 4'd1 && op <= 4'd7) begin
      ans = ref_alu(a, b, op);
      checkOutput("exec_alu_code", 32'(alu_code), 32'(op));
      checkOutput("exec_alu_a", 32'(alu_a), 32'(a));
      checkOutput("exec_alu_b", 32'(alu_b), 32'(b));
      checkOutput("exec_out_valid_low", 32'(bus.out_valid), 32'd0);
      if (dst != 0) model_regs[dst] = ans;
      model_retired = (model_retired + 1) % 256;
      sb.push_back('{data: ans, dst: dst, err: 1'b0, ret: 8'(model_retired)});
    end else begin
      checkOutput("illegal_alu_code", 32'(alu_code), 32'd0);
      checkOutput("illegal_out_valid", 32'(bus.out_valid), 32'd1);
      sb.push_back('{data: '0, dst: dst, err: 1'b1, ret: 8'(model_retired)});
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses required 0", sb.size());
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_dst    = '0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_imm_en = 1'b0;
    bus.in_imm    = '0;
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_out_err", 32'(bus.out_err), 32'd0);
    checkOutput("rst_retired", 32'(retired), 32'd0);
    checkOutput("rst_alu_code", 32'(alu_code), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Register reads after reset, load/add chain.
    applyStimulus(4'd6, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0);
    applyStimulus(4'd1, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5);
    applyStimulus(4'd1, 2'd2, 2'd1, 2'd0, 1'b1, 4'd3);
    // Wrap, sub, shift, not.
    applyStimulus(4'd1, 2'd1, 2'd0, 2'd0, 1'b1, 4'd15);
    applyStimulus(4'd1, 2'd1, 2'd1, 2'd0, 1'b1, 4'd1);
    applyStimulus(4'd1, 2'd2, 2'd0, 2'd0, 1'b1, 4'd2);
    applyStimulus(4'd1, 2'd3, 2'd0, 2'd0, 1'b1, 4'd3);
    applyStimulus(4'd2, 2'd1, 2'd2, 2'd3, 1'b0, 4'd9);
    applyStimulus(4'd3, 2'd1, 2'd3, 2'd0, 1'b1, 4'd1);
    applyStimulus(4'd7, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0);
    applyStimulus(4'd4, 2'd3, 2'd2, 2'd0, 1'b1, 4'd2);
    // Illegal opcodes, then read back registers to confirm nothing changed.
    applyStimulus(4'd0, 2'd1, 2'd2, 2'd3, 1'b1, 4'd7);
    applyStimulus(4'd9, 2'd2, 2'd1, 2'd3, 1'b0, 4'd4);
    applyStimulus(4'd1, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0);
    applyStimulus(4'd6, 2'd0, 2'd2, 2'd3, 1'b0, 4'd0);
    drain(20);

    // Backpressure: hold out_ready low while a result waits.
    hold_low = 1'b1;
    applyStimulus(4'd1, 2'd3, 2'd3, 2'd0, 1'b1, 4'd4);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_out_valid_rise", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      if (sb.size() != 0) begin
        checkOutput("bp_out_data", 32'(bus.out_data), 32'(sb[0].data));
        checkOutput("bp_out_dst", 32'(bus.out_dst), 32'(sb[0].dst));
      end
    end
    hold_low = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    applyStimulus(4'd5, 2'd1, 2'd3, 2'd2, 1'b0, 4'd0);
    checkOutput("bp_next_accept_wait", 32'(last_wait), 32'd0);
    drain(20);

    // Reset mid-EXEC discards the instruction and clears the register file.
    applyStimulus(4'd1, 2'd1, 2'd0, 2'd0, 1'b1, 4'd7);
    drain(20);
    bus.in_op     = 4'd1;
    bus.in_dst    = 2'd2;
    bus.in_src1   = 2'd1;
    bus.in_imm_en = 1'b1;
    bus.in_imm    = 4'd1;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    checkOutput("mid_exec_alu_a", 32'(alu_a), 32'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) model_regs[i] = '0;
    model_retired = 0;
    checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_retired", 32'(retired), 32'd0);
    checkOutput("mid_rst_out_data", 32'(bus.out_data), 32'd0);
    applyStimulus(4'd1, 2'd0, 2'd1, 2'd0, 1'b1, 4'd0);
    applyStimulus(4'd1, 2'd0, 2'd2, 2'd0, 1'b1, 4'd0);
    drain(20);

    // Randomized traffic with random downstream backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      if ($urandom_range(0, 4) == 0) op = 4'($urandom_range(0, 15));
      else                           op = 4'($urandom_range(1, 7));
      applyStimulus(op, RW'($urandom), RW'($urandom), RW'($urandom),
                    1'($urandom), W'($urandom));
    end
    drain(200);
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
